// File: rtl/dmem_line_responder_if.sv
// Memory-side line request/acknowledge bus between the data cache and
// dmem_line_responder.
//
// Signals (names follow the responder's point of view):
//   enable_i  cache -> mem   request valid, held until ack_o is seen
//   write_i   cache -> mem   1 = line write, 0 = line read
//   addr_i    cache -> mem   byte address, bits [4:0] ignored
//   data_i    cache -> mem   256-bit write line
//   ack_o     mem -> cache   one-cycle completion pulse
//   data_o    mem -> cache   256-bit read line, valid while ack_o is high
//   busy_o    mem -> cache   responder is not idle
//
// Modports: master = cache side, slave = responder side.
interface dmem_line_responder_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  modport master (
    output enable_i,
    output write_i,
    output addr_i,
    output data_i,
    input  ack_o,
    input  data_o,
    input  busy_o
  );

  modport slave (
    input  enable_i,
    input  write_i,
    input  addr_i,
    input  data_i,
    output ack_o,
    output data_o,
    output busy_o
  );
endinterface

// File: rtl/dmem_line_responder.sv
// Line-granular data memory answering the data cache's memory-side
// request/acknowledge protocol. One 256-bit line read or write is accepted at
// a time, held for LATENCY cycles, then committed (write) or returned (read)
// together with a single-cycle ack_o pulse, followed by a mandatory one-cycle
// turnaround.
//
// Parameters:
//   LATENCY  cycles from acceptance to the ack_o pulse, 1..255
//   DEPTH    number of 256-bit lines, power of two
//   IDX_W    line-index width, log2(DEPTH)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-low reset
//   bus      dmem_line_responder_if slave modport (request in, ack/data/busy out)
//
// The line array `mem` is not reset and may be preloaded hierarchically.
module dmem_line_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned IDX_W   = 9
) (
  input logic                  clk_i,
  input logic                  rst_i,
  dmem_line_responder_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StTurn
  } state_e;

  // Counter starts at LATENCY-1 so that the WAIT->ACK edge is E0+LATENCY.
  localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [255:0]     wdata_q, wdata_d;
  logic [255:0]     rdata_q;
  logic             complete;

  logic [255:0]     mem [DEPTH];

  // Only the line-index field of the address is meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Request fields are captured here only; later input changes are ignored.
        if (bus.enable_i) begin
          state_d = StWait;
          cnt_d   = CntLoad;
          idx_d   = bus.addr_i[5+IDX_W-1:5];
          wr_d    = bus.write_i;
          wdata_d = bus.data_i;
        end
      end
      StWait: begin
        // enable_i is not looked at: a dropped request still completes.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          complete = 1'b1;
          state_d  = StAck;
        end
      end
      StAck: begin
        state_d = StTurn;
      end
      StTurn: begin
        // The cache may still hold enable_i for one cycle after ack_o.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      // data_o only changes on read completion; writes leave it alone.
      if (complete && !wr_q) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // No reset on the array; reset forces StIdle, so a pending write never commits.
  always_ff @(posedge clk_i) begin
    if (complete && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.ack_o  = (state_q == StAck);
  assign bus.busy_o = (state_q != StIdle);
  assign bus.data_o = rdata_q;

endmodule

// File: doc/dmem_line_responder.md
# dmem_line_responder

Line-granular data memory that answers the data cache's memory-side request/acknowledge protocol. It accepts one 256-bit line read or write at a time and waits a fixed, parameterised latency. It then commits the write, or returns the read line, and pulses a single-cycle acknowledge. It sits between the data cache's memory port and the top-level system, replacing the ad-hoc testbench memory model.

## Interface
- LATENCY, 10: cycles from request acceptance to the ack_o pulse; legal range 1..255.
- DEPTH, 512: number of 256-bit lines; must be a power of two.
- IDX_W, 9: line-index width; must equal log2(DEPTH).
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  request valid; the cache holds it high until it sees ack_o.
- write_i  input  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[5+IDX_W-1:5].
- data_i  input  256  write line; sampled at acceptance.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line; valid while ack_o is high.
- busy_o  output  1  high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE: if enable_i=1, capture addr index, write_i and data_i, load counter with LATENCY-1, go to WAIT; otherwise stay.
  - WAIT: if counter≠0, decrement and stay. If counter=0, complete the request, assert ack_o, go to ACK.
  - ACK: ack_o high for this cycle only; go to TURN.
  - TURN: mandatory one-cycle turnaround; enable_i is ignored because the cache may still hold it high for one cycle after ack; go to IDLE.
- Completion of a write: mem[idx] <= captured data_i at the edge that enters ACK.
- Completion of a read: data_o <= mem[idx] at the same edge. data_o holds its value until the next read completes; writes never change data_o.
- Inputs are captured only at acceptance. Changes to addr_i, data_i or write_i during WAIT, ACK or TURN have no effect.
- enable_i dropping during WAIT does not abort the request; it completes and acks normally.
- Address index wraps modulo DEPTH; upper address bits beyond the index are ignored.
- Array contents are not cleared by reset. They are preloadable by the bench via hierarchical access to the array named `mem`.

## Timing
- Reset values: state IDLE, ack_o=0, data_o=0, busy_o=0, counter=0.
- Reset asserted mid-request drops the request silently. A pending write is not committed. No ack_o is produced after reset release.
- Request accepted at edge E0 (IDLE, enable_i=1). busy_o rises after E0. ack_o is high in the cycle following edge E0+LATENCY.
- ack_o is high for exactly one cycle. busy_o falls after edge E0+LATENCY+2.
- Minimum spacing between acceptances is LATENCY+3 edges.
- For LATENCY=1, WAIT lasts exactly one cycle (the counter loads 0).
- A read issued after a write to the same line returns the new data. Write commit precedes any later acceptance by construction.

## Test plan
- Reset, then read index 3 preloaded with 256'hA5…A5, LATENCY=10, enable_i held until ack -> ack_o high only in the cycle after edge E0+10, data_o=256'hA5…A5, busy_o low 2 cycles after ack.
- Write line 0xDEADBEEF repeated to addr 0x0000_0460, then read the same address -> write acks after 10 cycles; read returns the written line; data_o unchanged during the write's ack.
- Keep enable_i high continuously across back-to-back requests -> second acceptance occurs exactly LATENCY+3 edges after the first; no double ack; TURN cycle ignores enable_i.
- Change addr_i and data_i every cycle during WAIT of a write to addr 0x40 -> only line 2 is modified, with the data present at acceptance.
- Assert rst_i low 4 cycles into a write to line 7, release, read line 7 -> no ack during or after reset for the dropped write; line 7 retains its old contents.
- LATENCY=1 and DEPTH=512 with addr 0x0000_4020 -> ack in the cycle after E0+1; access wraps to index 1.
